// File: rtl/time_report_tx.sv
// Purpose: formats a snapshot of stopwatch/watch time as "<M>HH:MM:SS.CC\r\n"
//          and pushes the 14 bytes one per cycle into a UART TX FIFO write port.
// Latency: request in cycle 0 -> first push in cycle 2, last push in cycle 15,
//          o_busy low again in cycle 16.
// Backpressure: tx_full stalls the byte index; no push while full, nothing is
//          lost or duplicated. Requests while busy coalesce into one pending report.
// Ports: clk/rst (sync, active-high); i_req/i_mode/i_hour/i_min/i_sec/i_msec in;
//        tx_full in; o_push/o_tx_data/o_busy out.
// Optional feature: define TIME_REPORT_AUTO_EN for a periodic internal request
//        every AUTO_PERIOD cycles.
module time_report_tx #(
    parameter int          AUTO_PERIOD = 100_000_000,
    parameter logic [7:0]  SEP_CHAR    = 8'h3A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic       i_mode,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic [6:0] i_msec,
    input  logic       tx_full,
    output logic       o_push,
    output logic [7:0] o_tx_data,
    output logic       o_busy
);

    typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        pending_q, pending_d;
    logic        mode_q, mode_d;
    logic [4:0]  hour_q, hour_d;
    logic [5:0]  min_q, min_d;
    logic [5:0]  sec_q, sec_d;
    logic [6:0]  cs_q, cs_d;
    logic [7:0]  hour_bcd_q, hour_bcd_d;
    logic [7:0]  min_bcd_q, min_bcd_d;
    logic [7:0]  sec_bcd_q, sec_bcd_d;
    logic [7:0]  cs_bcd_q, cs_bcd_d;
    logic        auto_req;
    logic        req_in;

    // Two-digit BCD {tens, ones}; anything above 99 saturates to 99.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] c;
        logic [3:0] t;
        logic [3:0] o;
        c = (v > 7'd99) ? 7'd99 : v;
        t = 4'(c / 7'd10);
        o = 4'(c % 7'd10);
        return {t, o};
    endfunction

    function automatic logic [7:0] digit(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

`ifdef TIME_REPORT_AUTO_EN
    localparam int CNT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    logic [CNT_W-1:0] auto_cnt_q, auto_cnt_d;

    // Free-running regardless of state; wrap pulse behaves like i_req.
    always_comb begin
        auto_req   = (auto_cnt_q == CNT_W'(AUTO_PERIOD - 1));
        auto_cnt_d = auto_req ? '0 : auto_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) auto_cnt_q <= '0;
        else     auto_cnt_q <= auto_cnt_d;
    end
`else
    assign auto_req = 1'b0;
`endif

    assign req_in = i_req | auto_req;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        mode_d     = mode_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        cs_d       = cs_q;
        hour_bcd_d = hour_bcd_q;
        min_bcd_d  = min_bcd_q;
        sec_bcd_d  = sec_bcd_q;
        cs_bcd_d   = cs_bcd_q;
        case (state_q)
            IDLE: begin
                if (req_in || pending_q) begin
                    mode_d    = i_mode;
                    hour_d    = i_hour;
                    min_d     = i_min;
                    sec_d     = i_sec;
                    cs_d      = i_msec;
                    pending_d = 1'b0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                hour_bcd_d = to_bcd({2'b00, hour_q});
                min_bcd_d  = to_bcd({1'b0, min_q});
                sec_bcd_d  = to_bcd({1'b0, sec_q});
                cs_bcd_d   = to_bcd(cs_q);
                idx_d      = 4'd0;
                state_d    = SEND;
                if (req_in) pending_d = 1'b1;
            end
            SEND: begin
                if (req_in) pending_d = 1'b1;
                if (!tx_full) begin
                    if (idx_q == 4'd13) begin
                        idx_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte mux over the registered BCD digits; zero outside SEND.
    always_comb begin
        o_tx_data = 8'h00;
        if (state_q == SEND) begin
            case (idx_q)
                4'd0:    o_tx_data = mode_q ? 8'h57 : 8'h53;
                4'd1:    o_tx_data = digit(hour_bcd_q[7:4]);
                4'd2:    o_tx_data = digit(hour_bcd_q[3:0]);
                4'd3:    o_tx_data = SEP_CHAR;
                4'd4:    o_tx_data = digit(min_bcd_q[7:4]);
                4'd5:    o_tx_data = digit(min_bcd_q[3:0]);
                4'd6:    o_tx_data = SEP_CHAR;
                4'd7:    o_tx_data = digit(sec_bcd_q[7:4]);
                4'd8:    o_tx_data = digit(sec_bcd_q[3:0]);
                4'd9:    o_tx_data = 8'h2E;
                4'd10:   o_tx_data = digit(cs_bcd_q[7:4]);
                4'd11:   o_tx_data = digit(cs_bcd_q[3:0]);
                4'd12:   o_tx_data = 8'h0D;
                4'd13:   o_tx_data = 8'h0A;
                default: o_tx_data = 8'h00;
            endcase
        end
    end

    // Combinational so a write is never presented to a full FIFO.
    assign o_push = (state_q == SEND) && !tx_full;
    assign o_busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            pending_q  <= 1'b0;
            mode_q     <= 1'b0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            cs_q       <= '0;
            hour_bcd_q <= '0;
            min_bcd_q  <= '0;
            sec_bcd_q  <= '0;
            cs_bcd_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            mode_q     <= mode_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            cs_q       <= cs_d;
            hour_bcd_q <= hour_bcd_d;
            min_bcd_q  <= min_bcd_d;
            sec_bcd_q  <= sec_bcd_d;
            cs_bcd_q   <= cs_bcd_d;
        end
    end

endmodule
